// File: rtl/data_c_pipe_intc_s2m_addr_last_if.sv
// data_inf_c: valid/ready stream interface with a DSIZE-bit payload.
// Ports:
//   clock - clock of the stream. Both modports read it so that a checker can
//           confirm that the stream and the consuming logic share one clock.
// Signals:
//   valid - beat present (driven by the master)
//   ready - sink can accept the beat (driven by the slave)
//   data  - beat payload (driven by the master)
interface data_inf_c #(
    parameter int DSIZE = 8
) (
    input logic clock
);
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (input clock, input ready, output valid, output data);
    modport slaver (input clock, input valid, input data, output ready);
endinterface

// File: rtl/data_c_pipe_intc_s2m_addr_last.sv
// data_c_pipe_intc_s2m_addr_last: one-to-many packet router.
// A single upstream stream is steered to one of NUM downstream ports. The
// port is chosen by addr on the first beat of each packet and is held until
// the beat marked last completes its handshake. A main register plus a
// one-entry skid register give one cycle of latency at full throughput, and
// keep the upstream ready free of any combinational path from downstream.
// Ports:
//   clock    - core clock shared by every stream
//   rst_n    - asynchronous active-low reset
//   addr     - destination port index, used on the first beat of a packet
//   last     - final beat of the packet on s00
//   s00      - upstream stream (slave side)
//   m00      - NUM downstream streams (master side)
//   m_last   - per-port last flag, aligned with m00[k].valid
//   drop_cnt - saturating count of packets discarded for addr >= NUM
module data_c_pipe_intc_s2m_addr_last #(
    parameter int NUM   = 8,
    parameter int NSIZE = $clog2(NUM)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [NSIZE-1:0] addr,
    input  logic             last,
    data_inf_c.slaver        s00,
    data_inf_c.master        m00 [NUM-1:0],
    output logic [NUM-1:0]   m_last,
    output logic [15:0]      drop_cnt
);
    localparam int             DSIZE = $bits(s00.data);
    localparam int             NPOW  = 1 << NSIZE;
    localparam logic [NSIZE:0] NUM_W = (NSIZE + 1)'(NUM);

    logic [DSIZE-1:0] main_data_q, main_data_d;
    logic [NSIZE-1:0] main_dest_q, main_dest_d;
    logic             main_last_q, main_last_d;
    logic             main_vld_q,  main_vld_d;
    logic [DSIZE-1:0] skid_data_q, skid_data_d;
    logic [NSIZE-1:0] skid_dest_q, skid_dest_d;
    logic             skid_last_q, skid_last_d;
    logic             skid_vld_q,  skid_vld_d;
    logic             lock_q,      lock_d;
    logic [NSIZE-1:0] lock_dest_q, lock_dest_d;
    logic [15:0]      drop_q,      drop_d;
    logic             ready_q;

    logic [NPOW-1:0]  down_rdy_s;
    logic [NSIZE-1:0] dest_s;
    logic             dest_ok_s;
    logic             up_hs_s;
    logic             dn_hs_s;
    logic             load_beat_s;

    // Gather downstream ready; unused index codes read as not ready so the
    // lookup by main_dest never leaves the vector.
    for (genvar k = 0; k < NPOW; k++) begin : g_rdy
        if (k < NUM) begin : g_used
            assign down_rdy_s[k] = m00[k].ready;
        end else begin : g_pad
            assign down_rdy_s[k] = 1'b0;
        end
    end

    assign up_hs_s     = s00.valid & ready_q;
    assign dn_hs_s     = main_vld_q & down_rdy_s[main_dest_q];
    assign dest_s      = lock_q ? lock_dest_q : addr;
    assign dest_ok_s   = ({1'b0, dest_s} < NUM_W);
    // Beats for a non-existent port are accepted but never stored.
    assign load_beat_s = up_hs_s & dest_ok_s;

    // Next-state logic for the main/skid pipeline, route lock and drop count.
    always_comb begin
        main_data_d = main_data_q;
        main_dest_d = main_dest_q;
        main_last_d = main_last_q;
        main_vld_d  = main_vld_q;
        skid_data_d = skid_data_q;
        skid_dest_d = skid_dest_q;
        skid_last_d = skid_last_q;
        skid_vld_d  = skid_vld_q;
        lock_d      = lock_q;
        lock_dest_d = lock_dest_q;
        drop_d      = drop_q;

        if (!main_vld_q || dn_hs_s) begin
            // Main frees up: the older skid beat goes first to keep order.
            if (skid_vld_q) begin
                main_data_d = skid_data_q;
                main_dest_d = skid_dest_q;
                main_last_d = skid_last_q;
                main_vld_d  = 1'b1;
                skid_vld_d  = 1'b0;
            end else if (load_beat_s) begin
                main_data_d = s00.data;
                main_dest_d = dest_s;
                main_last_d = last;
                main_vld_d  = 1'b1;
            end else begin
                main_vld_d  = 1'b0;
            end
        end else if (load_beat_s) begin
            // Main stalled: park the beat; ready drops next cycle.
            skid_data_d = s00.data;
            skid_dest_d = dest_s;
            skid_last_d = last;
            skid_vld_d  = 1'b1;
        end else begin
            skid_vld_d  = skid_vld_q;
        end

        if (up_hs_s) begin
            if (last) begin
                lock_d = 1'b0;
            end else if (!lock_q) begin
                lock_d      = 1'b1;
                lock_dest_d = addr;
            end else begin
                lock_d = lock_q;
            end
            if (!dest_ok_s && last && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            lock_d = lock_q;
        end
    end

    // State registers; ready is registered from the next skid occupancy.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_dest_q <= '0;
            main_last_q <= 1'b0;
            main_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_dest_q <= '0;
            skid_last_q <= 1'b0;
            skid_vld_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_dest_q <= '0;
            drop_q      <= 16'd0;
            ready_q     <= 1'b0;
        end else begin
            main_data_q <= main_data_d;
            main_dest_q <= main_dest_d;
            main_last_q <= main_last_d;
            main_vld_q  <= main_vld_d;
            skid_data_q <= skid_data_d;
            skid_dest_q <= skid_dest_d;
            skid_last_q <= skid_last_d;
            skid_vld_q  <= skid_vld_d;
            lock_q      <= lock_d;
            lock_dest_q <= lock_dest_d;
            drop_q      <= drop_d;
            ready_q     <= ~skid_vld_d;
        end
    end

    assign s00.ready = ready_q;
    assign drop_cnt  = drop_q;

    // Only the port owning the main beat sees valid; data is broadcast.
    for (genvar k = 0; k < NUM; k++) begin : g_out
        assign m00[k].valid = main_vld_q && (main_dest_q == NSIZE'(k));
        assign m00[k].data  = main_data_q;
        assign m_last[k]    = main_vld_q && main_last_q && (main_dest_q == NSIZE'(k));
    end
endmodule

// data_c_pipe_intc_s2m_addr_last_clk_chk: simulation checker that every
// interface clock runs with the core clock. Rising edges are counted on each
// clock and compared on the falling edge of the core clock, when all counters
// of the same time step have settled.
// Ports:
//   clock    - core clock
//   if_clock - clocks of the attached interfaces
module data_c_pipe_intc_s2m_addr_last_clk_chk #(
    parameter int N = 1
) (
    input logic         clock,
    input logic [N-1:0] if_clock
);
    int clk_edges_q;
    int if_edges_q [N];

    // Count rising edges of the core clock.
    always @(posedge clock) begin
        clk_edges_q <= clk_edges_q + 1;
    end

    for (genvar k = 0; k < N; k++) begin : g_cnt
        // Count rising edges of one interface clock.
        always @(posedge if_clock[k]) begin
            if_edges_q[k] <= if_edges_q[k] + 1;
        end
    end

    // Any drift in edge counts means a foreign clock on an interface.
    always @(negedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (clk_edges_q != if_edges_q[k]) begin
                $error("interface %0d clock does not match clock", k);
                $stop;
            end
        end
    end
endmodule

// File: tb/tb_data_c_pipe_intc_s2m_addr_last.sv
module tb_data_c_pipe_intc_s2m_addr_last;
    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    // Instance 0 has NUM=4, instance 1 has NUM=5 (addr 5..7 invalid).
    data_inf_c #(.DSIZE(8)) s4 (.clock(clock));
    data_inf_c #(.DSIZE(8)) m4 [3:0] (.clock(clock));
    data_inf_c #(.DSIZE(8)) s5 (.clock(clock));
    data_inf_c #(.DSIZE(8)) m5 [4:0] (.clock(clock));

    logic       sv  [2];
    logic [7:0] sd  [2];
    logic       sl  [2];
    logic [2:0] sa  [2];
    logic [4:0] rdy [2];

    logic [3:0]  ml4, ov4;
    logic [4:0]  ml5, ov5;
    logic [15:0] dc4, dc5;
    logic [4:0]  ov  [2];
    logic [4:0]  ol  [2];
    logic [7:0]  od  [2][5];
    logic        sr  [2];
    logic [15:0] dcv [2];
    logic [4:0]  ck4;
    logic [5:0]  ck5;

    assign s4.valid = sv[0];
    assign s4.data  = sd[0];
    assign s5.valid = sv[1];
    assign s5.data  = sd[1];

    for (genvar k = 0; k < 4; k++) begin : g_m4
        assign m4[k].ready = rdy[0][k];
        assign ov4[k]      = m4[k].valid;
        assign od[0][k]    = m4[k].data;
    end
    for (genvar k = 0; k < 5; k++) begin : g_m5
        assign m5[k].ready = rdy[1][k];
        assign ov5[k]      = m5[k].valid;
        assign od[1][k]    = m5[k].data;
    end
    assign od[0][4] = 8'h00;
    assign ov[0]    = {1'b0, ov4};
    assign ov[1]    = ov5;
    assign ol[0]    = {1'b0, ml4};
    assign ol[1]    = ml5;
    assign sr[0]    = s4.ready;
    assign sr[1]    = s5.ready;
    assign dcv[0]   = dc4;
    assign dcv[1]   = dc5;
    assign ck4 = {s4.clock, m4[3].clock, m4[2].clock, m4[1].clock, m4[0].clock};
    assign ck5 = {s5.clock, m5[4].clock, m5[3].clock, m5[2].clock, m5[1].clock, m5[0].clock};

    data_c_pipe_intc_s2m_addr_last #(.NUM(4)) u4 (
        .clock(clock), .rst_n(rst_n), .addr(sa[0][1:0]), .last(sl[0]),
        .s00(s4), .m00(m4), .m_last(ml4), .drop_cnt(dc4));
    data_c_pipe_intc_s2m_addr_last #(.NUM(5)) u5 (
        .clock(clock), .rst_n(rst_n), .addr(sa[1]), .last(sl[1]),
        .s00(s5), .m00(m5), .m_last(ml5), .drop_cnt(dc5));
    data_c_pipe_intc_s2m_addr_last_clk_chk #(.N(5)) c4 (.clock(clock), .if_clock(ck4));
    data_c_pipe_intc_s2m_addr_last_clk_chk #(.N(6)) c5 (.clock(clock), .if_clock(ck5));

    // Reference model: an in-order queue of beats still owed downstream.
    typedef struct packed { logic [2:0] dest; logic [7:0] data; logic last; } beat_t;
    typedef struct packed { logic [2:0] addr; logic [7:0] data; logic last; } stim_t;
    beat_t mq   [2][$];
    stim_t stim [2][$];
    logic       m_lock  [2];
    logic [2:0] m_ldest [2];
    int         m_drop  [2];
    bit         m_en    [2];
    bit         acc     [2];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic v; logic [2:0] a; logic [7:0] d; logic l;
        logic [3:0] ev; logic [7:0] ed; logic [3:0] el;
    } row_t;
    row_t tbl [8];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=0x%0h required=0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_lock[i] = 1'b0; m_ldest[i] = 3'd0; m_drop[i] = 0; m_en[i] = 1'b0;
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            int  num = (i == 0) ? 4 : 5;
            int  n   = mq[i].size();
            chk("s_ready", i, 32'(sr[i]), 32'(m_en[i] && (n < 2)));
            chk("drop_cnt", i, 32'(dcv[i]), 32'(m_drop[i]));
            for (int k = 0; k < num; k++) begin
                bit ev = (n > 0) && (mq[i][0].dest == 3'(k));
                chk("valid", i * 8 + k, 32'(ov[i][k]), 32'(ev));
                chk("m_last", i * 8 + k, 32'(ol[i][k]), 32'(ev && mq[i][0].last));
                if (ev) chk("data", i * 8 + k, 32'(od[i][k]), 32'(mq[i][0].data));
                if (!rst_n) chk("reset_data", i * 8 + k, 32'(od[i][k]), 32'd0);
            end
        end
    endtask

    // Apply the routing rules to the inputs present before the coming edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int       num = (i == 0) ? 4 : 5;
            int       n   = mq[i].size();
            bit       up  = rst_n && sv[i] && m_en[i] && (n < 2);
            bit       dn  = rst_n && (n > 0) && rdy[i][mq[i][0].dest];
            logic [2:0] a, dest;
            acc[i] = up;
            if (!rst_n) begin
                mq[i].delete(); m_lock[i] = 1'b0; m_drop[i] = 0; m_en[i] = 1'b0;
            end else begin
                if (dn) void'(mq[i].pop_front());
                if (up) begin
                    a    = (i == 0) ? {1'b0, sa[i][1:0]} : sa[i];
                    dest = m_lock[i] ? m_ldest[i] : a;
                    if (sl[i]) m_lock[i] = 1'b0;
                    else if (!m_lock[i]) begin m_lock[i] = 1'b1; m_ldest[i] = a; end
                    if (int'(dest) < num) mq[i].push_back('{dest, sd[i], sl[i]});
                    else if (sl[i] && m_drop[i] < 65535) m_drop[i]++;
                end
                m_en[i] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_check();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin
            for (int i = 0; i < 2; i++) begin
                if (rnd) rdy[i] = 5'($urandom) | 5'($urandom);
                if (stim[i].size() > 0 && (!rnd || $urandom_range(3, 0) != 0)) begin
                    sv[i] = 1'b1; sa[i] = stim[i][0].addr; sd[i] = stim[i][0].data; sl[i] = stim[i][0].last;
                end else begin
                    sv[i] = 1'b0; sd[i] = 8'($urandom); sa[i] = 3'($urandom); sl[i] = 1'($urandom);
                end
            end
            cycle();
            for (int i = 0; i < 2; i++) if (acc[i]) void'(stim[i].pop_front());
        end
    endtask

    task automatic push_pkt(input logic [2:0] a, input int len, input logic [7:0] base);
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < len; b++)
                stim[i].push_back('{a, base + 8'(b), (b == len - 1)});
    endtask

    task automatic push_beat(input logic [2:0] a, input logic [7:0] d, input logic l);
        for (int i = 0; i < 2; i++) stim[i].push_back('{a, d, l});
    endtask

    task automatic set_rdy(input logic [4:0] r);
        rdy[0] = r; rdy[1] = r;
    endtask

    task automatic chk_drained(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk(nm, i, 32'(stim[i].size()), 32'd0);
            chk(nm, 10 + i, 32'(mq[i].size()), 32'd0);
        end
    endtask

    initial begin
        // Stimulus row: inputs, then NUM=4 outputs expected at that cycle.
        tbl[0] = '{1'b1, 3'd2, 8'h11, 1'b0, 4'b0000, 8'h00, 4'b0000};
        tbl[1] = '{1'b1, 3'd2, 8'h22, 1'b0, 4'b0100, 8'h11, 4'b0000};
        tbl[2] = '{1'b1, 3'd0, 8'h33, 1'b1, 4'b0100, 8'h22, 4'b0000};
        tbl[3] = '{1'b1, 3'd1, 8'hA1, 1'b0, 4'b0100, 8'h33, 4'b0100};
        tbl[4] = '{1'b1, 3'd3, 8'hA2, 1'b1, 4'b0010, 8'hA1, 4'b0000};
        tbl[5] = '{1'b1, 3'd3, 8'hB0, 1'b1, 4'b0010, 8'hA2, 4'b0010};
        tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 4'b1000, 8'hB0, 4'b1000};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 4'b0000, 8'h00, 4'b0000};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; sd[i] = 8'h00; sl[i] = 1'b0; sa[i] = 3'd0;
        end
        set_rdy(5'h1F);
        model_reset();
        @(negedge clock);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Directed table: 3-beat packet to port 2, then back-to-back A/B.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 2; i++) begin
                sv[i] = tbl[r].v; sa[i] = tbl[r].a; sd[i] = tbl[r].d; sl[i] = tbl[r].l;
            end
            chk("tbl_valid", r, 32'(ov[0][3:0]), 32'(tbl[r].ev));
            chk("tbl_m_last", r, 32'(ol[0][3:0]), 32'(tbl[r].el));
            chk("tbl_ready", r, 32'(sr[0]), 32'd1);
            for (int k = 0; k < 4; k++)
                if (tbl[r].ev[k]) chk("tbl_data", r, 32'(od[0][k]), 32'(tbl[r].ed));
            cycle();
        end

        // Port 1 stalls for 5 cycles mid-packet: one beat parks in skid.
        set_rdy(5'b11101);
        push_pkt(3'd1, 4, 8'h40);
        run(2, 1'b0);
        chk("skid_full_ready", 0, 32'(sr[0]), 32'd0);
        chk("skid_full_ready", 1, 32'(sr[1]), 32'd0);
        run(3, 1'b0);
        set_rdy(5'h1F);
        run(1, 1'b0);
        chk("ready_recover", 0, 32'(sr[0]), 32'd1);
        chk("ready_recover", 1, 32'(sr[1]), 32'd1);
        run(8, 1'b0);
        chk_drained("stall_drained");

        // addr changes on later beats of a locked packet are ignored.
        push_beat(3'd1, 8'h50, 1'b0);
        push_beat(3'd3, 8'h51, 1'b0);
        push_beat(3'd0, 8'h52, 1'b0);
        push_beat(3'd2, 8'h53, 1'b1);
        run(8, 1'b0);
        chk_drained("lock_drained");

        // addr=6 is invalid for NUM=5 (dropped) but is port 2 for NUM=4.
        push_pkt(3'd6, 3, 8'h60);
        push_pkt(3'd0, 2, 8'h70);
        run(10, 1'b0);
        chk("drop_cnt5", 1, 32'(dcv[1]), 32'd1);
        chk("drop_cnt4", 0, 32'(dcv[0]), 32'd0);
        chk_drained("drop_drained");

        // Reset mid-packet with the skid full.
        set_rdy(5'b11101);
        push_pkt(3'd1, 4, 8'h80);
        run(3, 1'b0);
        chk("pre_reset_ready", 0, 32'(sr[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_m_last", i, 32'(ol[i]), 32'd0);
            chk("rst_ready", i, 32'(sr[i]), 32'd0);
            chk("rst_drop", i, 32'(dcv[i]), 32'd0);
            stim[i].delete();
            sv[i] = 1'b0;
        end
        model_reset();
        cycle();
        @(negedge clock);
        rst_n = 1'b1;
        set_rdy(5'h1F);
        cycle();
        push_pkt(3'd3, 1, 8'h90);
        push_pkt(3'd2, 2, 8'hA0);
        run(8, 1'b0);
        chk_drained("post_reset_drained");

        // Randomized packets, addresses, bubbles and back-pressure.
        for (int p = 0; p < 60; p++)
            for (int i = 0; i < 2; i++) begin
                int          len = $urandom_range(4, 1);
                logic [2:0]  a   = 3'($urandom_range(7, 0));
                for (int b = 0; b < len; b++)
                    stim[i].push_back('{a, 8'($urandom), (b == len - 1)});
            end
        run(600, 1'b1);
        set_rdy(5'h1F);
        run(40, 1'b0);
        chk_drained("random_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
